// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter peripheral.
//   - Register byte offsets on the Minisys IO bus and their 2-bit selects
//     (decode uses address[2:1] only, so odd addresses alias).
//   - Transmit FSM state type.
//   - STATUS / CTRL bit positions.
//   - Baud divisor clamp applied when a divisor is latched for a frame.
package uart_pkg;

  localparam logic [2:0] UART_TXDATA  = 3'd0;
  localparam logic [2:0] UART_STATUS  = 3'd2;
  localparam logic [2:0] UART_BAUDDIV = 3'd4;
  localparam logic [2:0] UART_CTRL    = 3'd6;

  localparam logic [1:0] SEL_TXDATA  = UART_TXDATA[2:1];
  localparam logic [1:0] SEL_STATUS  = UART_STATUS[2:1];
  localparam logic [1:0] SEL_BAUDDIV = UART_BAUDDIV[2:1];
  localparam logic [1:0] SEL_CTRL    = UART_CTRL[2:1];

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;
  localparam int unsigned STAT_COUNT_W   = 4;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLEAR  = 2;

  // Divisors below 2 cannot produce a meaningful bit period.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with first-word-fall-through head.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   push, push_data: enqueue request; ignored when full
//   pop            : dequeue request; ignored when empty
//   clear          : empty the FIFO on this edge
//   head_data      : oldest entry, valid whenever empty=0
//   full, empty    : occupancy flags
//   count          : number of entries held (0..DEPTH)
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO
  // is dropped even when the head leaves on the same edge.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Minisys IO bus.
// The CPU pushes bytes into a FIFO; frames go out LSB first on tx with a
// programmable divisor (clock cycles per bit).
// Ports:
//   clock, reset   : cpu_clk and synchronous active-high reset
//   write_enable   : bus write strobe (mem_iowrite && uartctrl)
//   read_enable    : bus read strobe (mem_ioread && uartctrl)
//   address        : register byte address, decoded on [2:1]
//   write_data_in  : write data
//   read_data_out  : combinational read data, 0 when read_enable=0
//   tx             : registered serial output, idle high
//   interrupt      : registered level request (irq_en & empty & idle)
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd191
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data_in,
  output logic [15:0] read_data_out,
  output logic        tx,
  output logic        interrupt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    sel;
  logic          unused_addr_lsb;
  logic          wr_txdata;
  logic          wr_baud;
  logic          wr_ctrl;
  logic          rd_status;
  logic          clear_fifo;

  logic [15:0]   baud_div;
  logic          enable;
  logic          irq_en;
  logic          overflow;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  tx_state_t     state;
  logic [7:0]    shift;
  logic [15:0]   bit_div;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic          busy;
  logic          start_frame;
  logic [15:0]   latched_div;

  assign sel             = address[2:1];
  assign unused_addr_lsb = address[0];

  assign wr_txdata  = write_enable && (sel == SEL_TXDATA);
  assign wr_baud    = write_enable && (sel == SEL_BAUDDIV);
  assign wr_ctrl    = write_enable && (sel == SEL_CTRL);
  assign rd_status  = read_enable  && (sel == SEL_STATUS);
  assign clear_fifo = wr_ctrl && write_data_in[CTRL_CLEAR];

  assign busy        = (state != IDLE);
  assign latched_div = clamp_div(baud_div);

  // A frame starts from IDLE, or straight out of the last STOP cycle so
  // queued bytes go out back-to-back without an idle gap.
  assign start_frame = enable && !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && (bit_cnt == '0)));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_txdata),
    .pop       (start_frame),
    .clear     (clear_fifo),
    .push_data (write_data_in[7:0]),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Control and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_div <= DEFAULT_DIV;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) begin
        baud_div <= write_data_in;
      end
      if (wr_ctrl) begin
        enable <= write_data_in[CTRL_ENABLE];
        irq_en <= write_data_in[CTRL_IRQ_EN];
      end
      // A dropped byte outranks a same-cycle STATUS read so it is never lost.
      if (wr_txdata && fifo_full) begin
        overflow <= 1'b1;
      end else if (rd_status) begin
        overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM. bit_cnt counts down the remaining cycles of the current
  // bit; the divisor is captured per frame so BAUDDIV writes take effect
  // on the next frame only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_div <= clamp_div(DEFAULT_DIV);
      bit_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else if (start_frame) begin
      state   <= START;
      shift   <= fifo_head;
      bit_div <= latched_div;
      bit_cnt <= latched_div - 16'd1;
      bit_idx <= '0;
      tx      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_cnt == '0) begin
            state   <= DATA;
            bit_idx <= '0;
            bit_cnt <= bit_div - 16'd1;
            tx      <= shift[0];
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= bit_div - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // shift[0] is always the bit currently on the line.
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= irq_en && fifo_empty && !busy;
    end
  end

  always_comb begin
    read_data_out = '0;
    if (read_enable) begin
      case (sel)
        SEL_STATUS: begin
          read_data_out[STAT_BUSY]     = busy;
          read_data_out[STAT_FULL]     = fifo_full;
          read_data_out[STAT_EMPTY]    = fifo_empty;
          read_data_out[STAT_OVERFLOW] = overflow;
          read_data_out[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        end
        SEL_BAUDDIV: begin
          read_data_out = baud_div;
        end
        SEL_CTRL: begin
          read_data_out[CTRL_ENABLE] = enable;
          read_data_out[CTRL_IRQ_EN] = irq_en;
        end
        default: begin
          read_data_out = '0;
        end
      endcase
    end
  end

endmodule
